// File: rtl/tlb_cache_assoc.sv
// Thread-tagged set-associative TLB with per-set true LRU, duplicate-free fills
// and a one-set-per-cycle flush engine (global or per-thread).
module tlb_cache_assoc #(
  parameter int unsigned NUM_SETS    = 4,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned THREADS     = 4,
  parameter int unsigned VA_WIDTH    = 32,
  parameter int unsigned PA_WIDTH    = 20,
  parameter int unsigned PAGE_OFFSET = 12,
  localparam int unsigned TidW       = (THREADS > 1) ? $clog2(THREADS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                supervisor,
  input  logic                req_valid,
  input  logic [TidW-1:0]     req_thread_id,
  input  logic [VA_WIDTH-1:0] req_virt_addr,
  input  logic                req_write,
  output logic                rsp_valid,
  output logic                rsp_hit,
  output logic                rsp_fault,
  output logic [PA_WIDTH-1:0] rsp_phy_addr,
  input  logic                fill_valid,
  input  logic [TidW-1:0]     fill_thread_id,
  input  logic [VA_WIDTH-1:0] fill_virt_addr,
  input  logic [PA_WIDTH-1:0] fill_phy_addr,
  input  logic                fill_write_priv,
  input  logic                flush_req,
  input  logic                flush_all,
  input  logic [TidW-1:0]     flush_thread_id,
  output logic                flush_busy
);

  localparam int unsigned SetBits = $clog2(NUM_SETS);
  localparam int unsigned SetW    = (SetBits > 0) ? SetBits : 1;
  localparam int unsigned WayW    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned VpnW    = VA_WIDTH - PAGE_OFFSET;
  localparam int unsigned TagW    = VpnW - SetBits;
  localparam int unsigned PpnW    = PA_WIDTH - PAGE_OFFSET;

  typedef logic [WAYS-1:0][WayW-1:0] ages_t;
  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  function automatic logic [SetW-1:0] set_of(input logic [VA_WIDTH-1:0] va);
    logic [VpnW-1:0] vpn;
    vpn = va[VA_WIDTH-1:PAGE_OFFSET];
    return SetW'(vpn) & SetW'(NUM_SETS - 1);
  endfunction

  function automatic logic [TagW-1:0] tag_of(input logic [VA_WIDTH-1:0] va);
    logic [VpnW-1:0] vpn;
    vpn = va[VA_WIDTH-1:PAGE_OFFSET];
    return TagW'(vpn >> SetBits);
  endfunction

  // Ways younger than the touched one age by one; the touched way becomes youngest.
  function automatic ages_t touch(input ages_t a, input logic [WayW-1:0] way);
    ages_t r;
    r = a;
    for (int i = 0; i < WAYS; i++) begin
      if (a[i] < a[way]) r[i] = a[i] + 1'b1;
    end
    r[way] = '0;
    return r;
  endfunction

  logic            valid_q [NUM_SETS][WAYS];
  logic [TidW-1:0] tid_q   [NUM_SETS][WAYS];
  logic [TagW-1:0] tag_q   [NUM_SETS][WAYS];
  logic [PpnW-1:0] ppn_q   [NUM_SETS][WAYS];
  logic            wp_q    [NUM_SETS][WAYS];
  ages_t           age_q   [NUM_SETS];
  ages_t           age_d   [NUM_SETS];

  state_e          state_q, state_d;
  logic [SetW-1:0] fl_set_q, fl_set_d;
  logic            fl_all_q, fl_all_d;
  logic [TidW-1:0] fl_tid_q, fl_tid_d;

  logic            busy, touch_hit, fill_en;
  logic [SetW-1:0] rset, fset;
  logic [TagW-1:0] rtag, ftag;
  logic            hit_any, fmatch, finv;
  logic [WayW-1:0] hit_way, fmatch_way, finv_way, max_way, fway;

  assign busy      = (state_q == StFlush);
  assign touch_hit = req_valid & ~supervisor & ~busy & hit_any;
  assign fill_en   = fill_valid & ~busy;

  always_comb begin
    rset    = set_of(req_virt_addr);
    rtag    = tag_of(req_virt_addr);
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[rset][w] && tag_q[rset][w] == rtag && tid_q[rset][w] == req_thread_id) begin
        hit_any = 1'b1;
        hit_way = WayW'(w);
      end
    end
  end

  // Fill victim is chosen on ages after this cycle's hit touch, so a just-hit way is spared.
  always_comb begin
    fset       = set_of(fill_virt_addr);
    ftag       = tag_of(fill_virt_addr);
    age_d      = age_q;
    fmatch     = 1'b0;
    fmatch_way = '0;
    finv       = 1'b0;
    finv_way   = '0;
    max_way    = '0;
    if (touch_hit) age_d[rset] = touch(age_q[rset], hit_way);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[fset][w]) begin
        finv     = 1'b1;
        finv_way = WayW'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (age_d[fset][w] > age_d[fset][max_way]) max_way = WayW'(w);
      if (valid_q[fset][w] && tag_q[fset][w] == ftag && tid_q[fset][w] == fill_thread_id) begin
        fmatch     = 1'b1;
        fmatch_way = WayW'(w);
      end
    end
    fway = fmatch ? fmatch_way : (finv ? finv_way : max_way);
    if (fill_en) age_d[fset] = touch(age_d[fset], fway);
  end

  always_comb begin
    state_d  = state_q;
    fl_set_d = fl_set_q;
    fl_all_d = fl_all_q;
    fl_tid_d = fl_tid_q;
    case (state_q)
      StIdle: begin
        if (flush_req) begin
          state_d  = StFlush;
          fl_set_d = '0;
          fl_all_d = flush_all;
          fl_tid_d = flush_thread_id;
        end
      end
      StFlush: begin
        if (fl_set_q == SetW'(NUM_SETS - 1)) state_d = StIdle;
        else fl_set_d = fl_set_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      fl_set_q <= '0;
      fl_all_q <= 1'b0;
      fl_tid_q <= '0;
    end else begin
      state_q  <= state_d;
      fl_set_q <= fl_set_d;
      fl_all_q <= fl_all_d;
      fl_tid_q <= fl_tid_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w]  <= 1'b0;
          tid_q[s][w]    <= '0;
          tag_q[s][w]    <= '0;
          ppn_q[s][w]    <= '0;
          wp_q[s][w]     <= 1'b0;
          age_q[s][w]    <= WayW'(w);
        end
      end
    end else begin
      age_q <= age_d;
      if (fill_en) begin
        valid_q[fset][fway] <= 1'b1;
        tid_q[fset][fway]   <= fill_thread_id;
        tag_q[fset][fway]   <= ftag;
        ppn_q[fset][fway]   <= fill_phy_addr[PA_WIDTH-1:PAGE_OFFSET];
        wp_q[fset][fway]    <= fill_write_priv;
      end
      if (busy) begin
        for (int w = 0; w < WAYS; w++) begin
          if (fl_all_q || tid_q[fl_set_q][w] == fl_tid_q) valid_q[fl_set_q][w] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_valid    <= 1'b0;
      rsp_hit      <= 1'b0;
      rsp_fault    <= 1'b0;
      rsp_phy_addr <= '0;
    end else begin
      rsp_valid <= req_valid;
      if (req_valid && supervisor) begin
        rsp_hit      <= 1'b1;
        rsp_fault    <= 1'b0;
        rsp_phy_addr <= req_virt_addr[PA_WIDTH-1:0];
      end else if (touch_hit) begin
        rsp_hit      <= 1'b1;
        rsp_fault    <= req_write & ~wp_q[rset][hit_way];
        rsp_phy_addr <= {ppn_q[rset][hit_way], req_virt_addr[PAGE_OFFSET-1:0]};
      end else begin
        rsp_hit      <= 1'b0;
        rsp_fault    <= 1'b0;
        rsp_phy_addr <= '0;
      end
    end
  end

  assign flush_busy = busy;

endmodule

// File: tb/tb_tlb_cache_assoc.sv
// Directed bench for tlb_cache_assoc: stimulus pushes expected responses, a monitor
// pops and compares them in the cycle the response is due.
module tb_tlb_cache_assoc;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        supervisor = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_thread_id = '0;
  logic [31:0] req_virt_addr = '0;
  logic        req_write = 1'b0;
  logic        rsp_valid, rsp_hit, rsp_fault;
  logic [19:0] rsp_phy_addr;
  logic        fill_valid = 1'b0;
  logic [1:0]  fill_thread_id = '0;
  logic [31:0] fill_virt_addr = '0;
  logic [19:0] fill_phy_addr = '0;
  logic        fill_write_priv = 1'b0;
  logic        flush_req = 1'b0;
  logic        flush_all = 1'b0;
  logic [1:0]  flush_thread_id = '0;
  logic        flush_busy;

  tlb_cache_assoc dut (
    .clock          (clock),
    .reset          (reset),
    .supervisor     (supervisor),
    .req_valid      (req_valid),
    .req_thread_id  (req_thread_id),
    .req_virt_addr  (req_virt_addr),
    .req_write      (req_write),
    .rsp_valid      (rsp_valid),
    .rsp_hit        (rsp_hit),
    .rsp_fault      (rsp_fault),
    .rsp_phy_addr   (rsp_phy_addr),
    .fill_valid     (fill_valid),
    .fill_thread_id (fill_thread_id),
    .fill_virt_addr (fill_virt_addr),
    .fill_phy_addr  (fill_phy_addr),
    .fill_write_priv(fill_write_priv),
    .flush_req      (flush_req),
    .flush_all      (flush_all),
    .flush_thread_id(flush_thread_id),
    .flush_busy     (flush_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic        hit;
    logic        fault;
    logic [19:0] pa;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: a due expectation is compared in full; any other rsp_valid is spurious.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        tests++;
        if (rsp_valid !== 1'b1 || rsp_hit !== e.hit || rsp_fault !== e.fault ||
            rsp_phy_addr !== e.pa) begin
          fails++;
          $display("FAIL %s: got valid=%b hit=%b fault=%b pa=%05h, want valid=1 hit=%b fault=%b pa=%05h",
                   e.name, rsp_valid, rsp_hit, rsp_fault, rsp_phy_addr, e.hit, e.fault, e.pa);
        end
      end else if (rsp_valid !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL spurious_rsp: got rsp_valid=%b at cycle %0d, want 0", rsp_valid, cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, want);
    end
  endtask

  task automatic lookup(input logic [1:0] tid, input logic [31:0] va, input logic wr,
                        input logic sup, input logic eh, input logic ef,
                        input logic [19:0] epa, input string nm);
    exp_t e;
    req_valid     = 1'b1;
    req_thread_id = tid;
    req_virt_addr = va;
    req_write     = wr;
    supervisor    = sup;
    e.due = cyc + 1; e.hit = eh; e.fault = ef; e.pa = epa; e.name = nm;
    exp_q.push_back(e);
    @(negedge clock);
    req_valid  = 1'b0;
    req_write  = 1'b0;
    supervisor = 1'b0;
  endtask

  task automatic fill(input logic [1:0] tid, input logic [31:0] va, input logic [19:0] pa,
                      input logic priv);
    fill_valid      = 1'b1;
    fill_thread_id  = tid;
    fill_virt_addr  = va;
    fill_phy_addr   = pa;
    fill_write_priv = priv;
    @(negedge clock);
    fill_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_hit", {31'd0, rsp_hit}, 32'd0);
    check("reset_rsp_pa", {12'd0, rsp_phy_addr}, 32'd0);
    check("reset_flush_busy", {31'd0, flush_busy}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    lookup(0, 32'h0000_3ABC, 0, 0, 0, 0, 20'h0, "cold_miss");
    fill(0, 32'h0000_3000, 20'h57000, 1);
    lookup(0, 32'h0000_3ABC, 0, 0, 1, 0, 20'h57ABC, "t0_hit");
    lookup(1, 32'h0000_3ABC, 0, 0, 0, 0, 20'h0, "t1_miss");

    // Set 0: 0x4 stays recently used, so 0x8 is the LRU victim for 0xC.
    fill(0, 32'h0000_4000, 20'h11000, 1);
    lookup(0, 32'h0000_4123, 0, 0, 1, 0, 20'h11123, "lru_touch4_a");
    fill(0, 32'h0000_8000, 20'h22000, 1);
    lookup(0, 32'h0000_4123, 0, 0, 1, 0, 20'h11123, "lru_touch4_b");
    fill(0, 32'h0000_C000, 20'h33000, 1);
    lookup(0, 32'h0000_4123, 0, 0, 1, 0, 20'h11123, "lru_keep4");
    lookup(0, 32'h0000_C456, 0, 0, 1, 0, 20'h33456, "lru_newC");
    lookup(0, 32'h0000_8000, 0, 0, 0, 0, 20'h0, "lru_evict8");

    // Set 1: privilege fault, in-place refill, then LRU confirms only one way was used.
    fill(0, 32'h0000_5000, 20'h44000, 0);
    lookup(0, 32'h0000_5010, 1, 0, 1, 1, 20'h44010, "store_fault");
    lookup(0, 32'h0000_5010, 0, 0, 1, 0, 20'h44010, "load_nofault");
    fill(0, 32'h0000_5000, 20'h44000, 1);
    lookup(0, 32'h0000_5010, 1, 0, 1, 0, 20'h44010, "refill_store_ok");
    fill(0, 32'h0000_9000, 20'h66000, 1);
    lookup(0, 32'h0000_9020, 0, 0, 1, 0, 20'h66020, "second_way_free");
    lookup(0, 32'h0000_5010, 1, 0, 1, 0, 20'h44010, "touch5");
    fill(0, 32'h0000_D000, 20'h77000, 1);
    lookup(0, 32'h0000_9020, 0, 0, 0, 0, 20'h0, "evict9");
    lookup(0, 32'h0000_D030, 0, 0, 1, 0, 20'h77030, "hitD");
    lookup(0, 32'h0000_5010, 0, 0, 1, 0, 20'h44010, "keep5");

    // Per-thread flush of thread 1.
    fill(1, 32'h0000_2000, 20'h88000, 1);
    lookup(1, 32'h0000_2123, 0, 0, 1, 0, 20'h88123, "t1_pre_flush");
    flush_all       = 1'b0;
    flush_thread_id = 2'd1;
    flush_req       = 1'b1;
    @(negedge clock);
    flush_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("flush_busy_%0d", i), {31'd0, flush_busy}, 32'd1);
      if (i == 0) begin
        fill_valid      = 1'b1;
        fill_thread_id  = 2'd0;
        fill_virt_addr  = 32'h0000_6000;
        fill_phy_addr   = 20'h99000;
        fill_write_priv = 1'b1;
      end
      lookup(0, 32'h0000_3ABC, 0, 0, 0, 0, 20'h0, $sformatf("busy_miss_%0d", i));
      fill_valid = 1'b0;
    end
    check("flush_busy_done", {31'd0, flush_busy}, 32'd0);
    lookup(0, 32'h0000_3ABC, 0, 0, 1, 0, 20'h57ABC, "t0_survives");
    lookup(1, 32'h0000_2123, 0, 0, 0, 0, 20'h0, "t1_flushed");
    lookup(0, 32'h0000_6000, 0, 0, 0, 0, 20'h0, "busy_fill_dropped");
    lookup(0, 32'h0000_4123, 0, 0, 1, 0, 20'h11123, "t0_set0_survives");

    lookup(0, 32'hFFFF_2345, 1, 1, 1, 0, 20'hF2345, "bypass");
    lookup(3, 32'h0000_3ABC, 0, 1, 1, 0, 20'h03ABC, "bypass_ignores_tlb");

    // Async reset in the middle of a global flush.
    flush_all = 1'b1;
    flush_req = 1'b1;
    @(negedge clock);
    flush_req = 1'b0;
    @(negedge clock);
    check("mid_flush_busy", {31'd0, flush_busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("reset_clears_busy", {31'd0, flush_busy}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_reset_busy", {31'd0, flush_busy}, 32'd0);
    lookup(0, 32'h0000_3ABC, 0, 0, 0, 0, 20'h0, "post_reset_miss3");
    lookup(0, 32'h0000_5010, 0, 0, 0, 0, 20'h0, "post_reset_miss5");
    lookup(0, 32'h0000_4123, 0, 0, 0, 0, 20'h0, "post_reset_miss4");

    @(negedge clock);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tlb_cache_assoc.md
# tlb_cache_assoc

Parametrised, thread-tagged, set-associative TLB for the core's fetch and memory stages. It translates a virtual address to a physical address with a registered one-cycle response, enforces per-page write privilege and accepts fills from the page-walk/TLBWrite path. It adds true per-set LRU, duplicate-free fills and a multi-cycle flush engine (global or per-thread). It replaces the fixed-geometry TLB inside the I-cache and D-cache tops.

## Interface
- NUM_SETS, 4, sets; power of two, ≥1
- WAYS, 2, ways per set; power of two, ≥1
- THREADS, 4, hardware threads; entries are tagged with thread id
- VA_WIDTH, 32, virtual address bits
- PA_WIDTH, 20, physical address bits
- PAGE_OFFSET, 12, page offset bits; VPN = VA[VA_WIDTH-1:PAGE_OFFSET], PPN = PA[PA_WIDTH-1:PAGE_OFFSET]
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- supervisor  in  1  1 = virtual memory disabled (bypass)
- req_valid  in  1  lookup request
- req_thread_id  in  log2(THREADS)  requesting thread
- req_virt_addr  in  VA_WIDTH  virtual address
- req_write  in  1  request is a store
- rsp_valid  out  1  response valid, one cycle after req_valid
- rsp_hit  out  1  translation found (or bypass)
- rsp_fault  out  1  hit on a store to a page without write privilege
- rsp_phy_addr  out  PA_WIDTH  translated address; 0 when !rsp_hit
- fill_valid  in  1  install translation
- fill_thread_id  in  log2(THREADS)  owning thread
- fill_virt_addr  in  VA_WIDTH  virtual address (offset ignored)
- fill_phy_addr  in  PA_WIDTH  physical address (offset ignored)
- fill_write_priv  in  1  write privilege of page
- flush_req  in  1  start invalidation (pulse)
- flush_all  in  1  1 = all threads, 0 = only flush_thread_id
- flush_thread_id  in  log2(THREADS)  thread to flush
- flush_busy  out  1  flush engine active

## Operation
- Set index = VPN[log2(NUM_SETS)-1:0]; tag = remaining VPN bits. Entry = {valid, thread_id, tag, ppn, write_priv}.
- Lookup hit: valid & tag match & thread_id match. At most one way hits (fills never create duplicates).
- Hit: rsp_hit=1, rsp_phy_addr = {ppn, va offset}, rsp_fault = req_write & !write_priv. Miss: rsp_hit=0, rsp_fault=0.
- Bypass (supervisor=1): rsp_hit=1, rsp_fault=0, rsp_phy_addr = req_virt_addr[PA_WIDTH-1:0]; no LRU update.
- LRU: per-way age counter, log2(WAYS) bits. On touch of way w: ages younger than age[w] increment, age[w]=0. Touch = lookup hit (including faulting hits) or fill.
- Fill way selection, in priority: way already holding the same {thread, tag} (overwrite in place); else lowest-index invalid way; else the way with maximum age.
- Flush FSM: IDLE -> FLUSH on flush_req (latched flush_all/flush_thread_id). FLUSH walks set 0..NUM_SETS-1, one set per cycle, clearing valid on matching entries (all, or thread_id == latched id). Ages are untouched. After the last set, return to IDLE. flush_busy=1 throughout FLUSH.
- While flush_busy: lookups respond rsp_valid=1, rsp_hit=0 (bypass still hits); fills are dropped; flush_req is ignored.

## Timing
- Reset: all valid=0, ages[way]=way index, FSM=IDLE. Outputs are 0: rsp_valid, rsp_hit, rsp_fault, rsp_phy_addr, flush_busy.
- Lookup latency: exactly 1 cycle; a full request rate of one per cycle is supported; response registers clear to 0 in cycles with no request.
- Fill and lookup in the same cycle: lookup sees pre-fill contents; fill takes effect next cycle. If both touch the same set, the fill's LRU update is applied after the hit's.
- Flush latency: flush_busy rises the cycle after flush_req and lasts NUM_SETS cycles. A lookup is guaranteed to see the flushed state from the cycle flush_busy falls.
- Reset asserted mid-flush or mid-response: state clears immediately (async); no pending response is emitted after deassertion.

## Test plan
- Reset, then lookup thread 0 VA 0x0000_3ABC (user) -> next cycle rsp_valid=1, rsp_hit=0, rsp_phy_addr=0.
- Fill t0 VA 0x0000_3000 -> PA 0x5_7000, priv=1; lookup t0 VA 0x0000_3ABC -> hit, PA 0x57ABC; same VA from t1 -> miss.
- Fill three VPNs mapping to set 0 (VPN 0x4, 0x8, 0xC, t0) after touching 0x4 between fills -> 0x8 evicted; 0x4 and 0xC hit.
- Fill t0 VPN 0x5 priv=0; store lookup -> rsp_hit=1, rsp_fault=1; load lookup -> fault=0; refill the same VPN with priv=1 -> no second way used, store fault=0.
- Fill entries for t0 and t1; flush_req with flush_all=0 and id=1 -> flush_busy high for 4 cycles, lookups miss during it; afterwards t0 hits and t1 misses.
- supervisor=1, VA 0xFFFF_2345 -> rsp_hit=1, PA 0xF2345, independent of contents; assert reset during a flush -> flush_busy=0 and all lookups miss.
